// File: rtl/contador_pessoas.sv
// Cabin occupancy counter (0..3) driven by debounced entry/exit beam sensors.
// Events are gated by the door state; outputs feed the occupancy display and controller.

module contador_pessoas_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic nivel,
    output logic evento
);

    typedef enum logic [1:0] {BAIXO, SUBINDO, ALTO, DESCENDO} estado_t;

    localparam logic [3:0] LIMITE = 4'(DEBOUNCE - 1);

    estado_t    estado;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= BAIXO;
            cnt    <= '0;
        end else begin
            case (estado)
                BAIXO: begin
                    if (nivel) begin
                        estado <= SUBINDO;
                        cnt    <= 4'd1;
                    end
                end
                SUBINDO: begin
                    if (!nivel) begin
                        estado <= BAIXO;
                        cnt    <= '0;
                    end else if (cnt == LIMITE) begin
                        estado <= ALTO;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ALTO: begin
                    if (!nivel) begin
                        estado <= DESCENDO;
                        cnt    <= 4'd1;
                    end
                end
                DESCENDO: begin
                    if (nivel) begin
                        estado <= ALTO;
                    end else if (cnt == LIMITE) begin
                        estado <= BAIXO;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    estado <= BAIXO;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Event is decoded from the qualifying transition so occupancy registers it
    // on the very edge the FSM enters ALTO.
    assign evento = (estado == SUBINDO) && nivel && (cnt == LIMITE);

endmodule

module contador_pessoas #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_entrada,
    input  logic sensor_saida,
    input  logic porta_aberta,
    output logic A,
    output logic B,
    output logic lotado,
    output logic vazio,
    output logic rejeitado
);

    logic       s1_entrada, s2_entrada;
    logic       s1_saida, s2_saida;
    logic       evento_entrada, evento_saida;
    logic [1:0] n, n_saida, n_prox;
    logic       rej_prox;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_entrada <= 1'b0;
            s2_entrada <= 1'b0;
            s1_saida   <= 1'b0;
            s2_saida   <= 1'b0;
        end else begin
            s1_entrada <= sensor_entrada;
            s2_entrada <= s1_entrada;
            s1_saida   <= sensor_saida;
            s2_saida   <= s1_saida;
        end
    end

    contador_pessoas_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_entrada (
        .clk    (clk),
        .reset  (reset),
        .nivel  (s2_entrada),
        .evento (evento_entrada)
    );

    contador_pessoas_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_saida (
        .clk    (clk),
        .reset  (reset),
        .nivel  (s2_saida),
        .evento (evento_saida)
    );

    // Exit is applied first; entry is then judged against the post-exit value.
    always_comb begin
        n_saida = n;
        if (evento_saida && porta_aberta && (n != 2'd0))
            n_saida = n - 2'd1;
        n_prox   = n_saida;
        rej_prox = 1'b0;
        if (evento_entrada) begin
            if (porta_aberta && (n_saida != 2'd3))
                n_prox = n_saida + 2'd1;
            else
                rej_prox = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n         <= '0;
            lotado    <= 1'b0;
            vazio     <= 1'b1;
            rejeitado <= 1'b0;
        end else begin
            n         <= n_prox;
            lotado    <= (n_prox == 2'd3);
            vazio     <= (n_prox == 2'd0);
            rejeitado <= rej_prox;
        end
    end

    assign A = n[1];
    assign B = n[0];

endmodule

// File: tb/tb_contador_pessoas.sv
// Scoreboard bench for contador_pessoas: stimulus queues expected output changes,
// a monitor compares every observed change of {A,B,lotado,vazio,rejeitado}.

module tb_contador_pessoas;

    localparam int LAT = 6;  // DEBOUNCE + 2 edges from sensor rise to output update

    logic clk = 1'b0;
    logic reset, sensor_entrada, sensor_saida, porta_aberta;
    logic A, B, lotado, vazio, rejeitado;

    contador_pessoas #(.DEBOUNCE(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sensor_entrada (sensor_entrada),
        .sensor_saida   (sensor_saida),
        .porta_aberta   (porta_aberta),
        .A              (A),
        .B              (B),
        .lotado         (lotado),
        .vazio          (vazio),
        .rejeitado      (rejeitado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] val;
        int         cyc;
    } exp_t;

    exp_t fila[$];
    int   checks = 0;
    int   passes = 0;
    int   t0;
    bit   mon_en = 1'b0;

    wire [4:0] saida = {A, B, lotado, vazio, rejeitado};

    task automatic push(input logic [4:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        fila.push_back(e);
    endtask

    task automatic espera(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic aperta(input logic e, input logic s);
        sensor_entrada = e;
        sensor_saida   = s;
        t0 = cyc;
    endtask

    task automatic solta_e_espera(input int alto, input int baixo);
        espera(alto);
        sensor_entrada = 1'b0;
        sensor_saida   = 1'b0;
        espera(baixo);
    endtask

    // Monitor: any change in the output vector must match the next queued expectation.
    logic [4:0] anterior;
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            anterior = saida;
        end else if (saida !== anterior) begin
            checks++;
            if (fila.size() == 0) begin
                $display("FAIL unexpected_change got=%b prev=%b cyc=%0d", saida, anterior, cyc);
            end else begin
                e = fila.pop_front();
                if (saida === e.val && cyc == e.cyc)
                    passes++;
                else
                    $display("FAIL out_change got=%b@%0d exp=%b@%0d", saida, cyc, e.val, e.cyc);
            end
            anterior = saida;
        end
    end

    initial begin
        reset = 1'b1;
        sensor_entrada = 1'b0;
        sensor_saida   = 1'b0;
        porta_aberta   = 1'b0;
        espera(2);

        checks++;
        if (saida === 5'b00010) passes++;
        else $display("FAIL reset_state got=%b exp=%b", saida, 5'b00010);

        mon_en = 1'b1;
        reset  = 1'b0;
        espera(20);

        // Three entries with the door open, then a refused fourth.
        porta_aberta = 1'b1;
        aperta(1, 0); push(5'b01000, t0 + LAT); solta_e_espera(8, 8);
        aperta(1, 0); push(5'b10000, t0 + LAT); solta_e_espera(8, 8);
        aperta(1, 0); push(5'b11100, t0 + LAT); solta_e_espera(8, 8);
        aperta(1, 0); push(5'b11101, t0 + LAT); push(5'b11100, t0 + LAT + 1); solta_e_espera(8, 8);

        // Short glitches must not qualify (a qualified one would pulse rejeitado at n=3).
        for (int g = 1; g <= 3; g++) begin
            aperta(1, 0);
            solta_e_espera(g, 8);
        end

        aperta(0, 1); push(5'b10000, t0 + LAT); solta_e_espera(8, 8);

        // Door closed at n=2: entry refused, exit discarded.
        porta_aberta = 1'b0;
        aperta(1, 0); push(5'b10001, t0 + LAT); push(5'b10000, t0 + LAT + 1); solta_e_espera(8, 8);
        aperta(0, 1); solta_e_espera(8, 8);
        porta_aberta = 1'b1;

        // Simultaneous entry/exit at n=3: no net change, no rejection.
        aperta(1, 0); push(5'b11100, t0 + LAT); solta_e_espera(8, 8);
        aperta(1, 1); solta_e_espera(8, 8);

        aperta(0, 1); push(5'b10000, t0 + LAT); solta_e_espera(8, 8);
        aperta(0, 1); push(5'b01000, t0 + LAT); solta_e_espera(8, 8);
        aperta(0, 1); push(5'b00010, t0 + LAT); solta_e_espera(8, 8);

        // Simultaneous at n=0 gives n=1; then exits down to and below zero.
        aperta(1, 1); push(5'b01000, t0 + LAT); solta_e_espera(8, 8);
        aperta(0, 1); push(5'b00010, t0 + LAT); solta_e_espera(8, 8);
        aperta(0, 1); solta_e_espera(8, 8);

        // Reset during an entry debounce at n=2; held sensor then counts once.
        aperta(1, 0); push(5'b01000, t0 + LAT); solta_e_espera(8, 8);
        aperta(1, 0); push(5'b10000, t0 + LAT); solta_e_espera(8, 8);
        aperta(1, 0);
        espera(3);
        reset = 1'b1;
        push(5'b00010, cyc + 1);
        espera(1);
        reset = 1'b0;
        push(5'b01000, cyc + LAT);
        solta_e_espera(10, 10);

        espera(10);
        checks++;
        if (fila.size() == 0) passes++;
        else $display("FAIL pending_expectations got=%0d exp=0", fila.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/contador_pessoas.md
# contador_pessoas

Tracks the number of passengers inside the cabin, from 0 to 3, using two door-mounted presence sensors, one for entry and one for exit. Each sensor is synchronized and debounced, and the door state gates every event. The block drives the 2-bit occupancy code `A`/`B` directly into the cabin's 7-segment occupancy display decoder. It also flags full, empty and rejected-entry conditions for the elevator controller.

## Interface
- `DEBOUNCE`, default 4: consecutive synchronized-high or synchronized-low cycles required to accept a sensor level change. Legal range is 2..15. The debounce counter is 4 bits.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous reset, active-high.
- `sensor_entrada` input 1: raw entry-beam sensor, asynchronous, high while a person crosses inward.
- `sensor_saida` input 1: raw exit-beam sensor, asynchronous, high while a person crosses outward.
- `porta_aberta` input 1: door-open status from the controller, synchronous to `clk`.
- `A` output 1: occupancy MSB, registered.
- `B` output 1: occupancy LSB, registered.
- `lotado` output 1: high when occupancy equals 3, registered.
- `vazio` output 1: high when occupancy equals 0, registered.
- `rejeitado` output 1: one-cycle pulse when an entry is refused, registered.

## Operation
**Synchronizer**
- Each sensor passes through a 2-flop synchronizer (`s1`, `s2`).
- All downstream logic uses `s2` only.

**Debounce FSM (one per sensor, identical)**
- States: `BAIXO`, `SUBINDO`, `ALTO`, `DESCENDO`, plus a 4-bit counter `cnt`.
- `BAIXO`: if `s2`=1, go to `SUBINDO` with `cnt`=1.
- `SUBINDO`:
  - if `s2`=0, return to `BAIXO` with `cnt`=0;
  - else if `cnt`=DEBOUNCE-1, go to `ALTO` and assert `evento`=1 for exactly one cycle;
  - else `cnt`++.
- `ALTO`: if `s2`=0, go to `DESCENDO` with `cnt`=1.
- `DESCENDO`:
  - if `s2`=1, return to `ALTO`;
  - else if `cnt`=DEBOUNCE-1, go to `BAIXO`;
  - else `cnt`++.
- Consequences:
  - Only the debounced rising edge generates an event; one beam interruption equals one person.
  - Pulses shorter than DEBOUNCE cycles, measured at `s2`, are ignored.

**Occupancy update**
- Occupancy is a 2-bit register `n`, with `A`=`n[1]` and `B`=`n[0]`.
- `n` is evaluated in the cycle where `evento_saida` and/or `evento_entrada` is high, and the result is registered at the next edge.
- Door closed (`porta_aberta`=0):
  - a pending exit event is discarded;
  - a pending entry event is discarded and `rejeitado` pulses.
- Door open:
  - The exit is applied first: if `n`>0 then `n`−1, and an exit at `n`=0 is silently ignored.
  - The entry is then evaluated against the post-exit value: if it is below 3, increment; otherwise do not change and pulse `rejeitado`.
  - Simultaneous exit and entry therefore give a net change of 0 when 1≤`n`≤3.
  - At `n`=0 the simultaneous result is `n`=1.
- There is no wrap-around in either direction; `n` saturates at 0 and 3.
- `lotado` and `vazio` are registered from the next value of `n`, so they always match `A`/`B` in the same cycle.

## Timing
- Reset values, applied at the first `clk` edge with `reset`=1:
  - `s1`, `s2` = 0; FSMs in `BAIXO` with `cnt`=0; `n`=0.
  - `A`=0, `B`=0, `vazio`=1, `lotado`=0, `rejeitado`=0.
- Reset takes priority over all events.
- Reset mid-debounce discards the partial count. A sensor held high through reset is re-qualified after release and yields exactly one event.
- Latency: if `sensor_entrada` rises before edge 1 and stays high, `s2`=1 after edge 2, `SUBINDO` is entered at edge 3, and `evento` is high after edge DEBOUNCE+1. `A`/`B`/`lotado`/`vazio`/`rejeitado` update at edge DEBOUNCE+2. For DEBOUNCE=4 this is edge 6.
- `rejeitado` is high for exactly one cycle per refused entry and never coincides with a change of `n` caused by the same entry.
- Throughput: a second person on the same sensor needs at least DEBOUNCE low cycles followed by DEBOUNCE high cycles.

## Test plan
- Reset, then idle for 20 cycles -> `A`=0, `B`=0, `vazio`=1, `lotado`=0, `rejeitado`=0 throughout.
- DEBOUNCE=4, `porta_aberta`=1, three entry pulses of 8 cycles separated by 8 low cycles:
  - `AB` steps 01, 10, 11;
  - the first update occurs exactly at edge 6 after the first pulse starts;
  - `lotado`=1 after the third pulse;
  - a fourth pulse leaves `AB`=11 and gives a single-cycle `rejeitado`.
- Entry glitches of 1, 2 and 3 cycles at DEBOUNCE=4 -> no change to `AB` and no `rejeitado`.
- At `n`=2 with `porta_aberta`=0, one entry pulse and one exit pulse -> `AB` stays 10 and `rejeitado` pulses once.
- At `n`=3, entry and exit pulses aligned to the same cycle with the door open -> `AB` stays 11, `rejeitado`=0. At `n`=0 with the same stimulus -> `AB`=01.
- At `n`=0, exit pulse -> `AB` stays 00 and `vazio` stays 1. Assert `reset` for 1 cycle during an in-progress entry debounce at `n`=2 -> `AB`=00 next cycle. The held sensor then counts once -> `AB`=01.
